// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit with HI/LO result registers.
// Optional feature macro: MULTDIV_FAST_ZERO_EN short-circuits zero operands straight to RESULT.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       dbg_state_o
);

  // Handshake: start is sampled only while the unit is idle (busy==0). Every accepted
  // MULT/DIV command ends in exactly one done pulse, in a cycle where busy is low; a DIV by
  // zero also raises div0 alongside done. Reset aborts any command without a done pulse.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [1:0]    OP_MULT  = 2'b01;
  localparam logic [1:0]    OP_DIV   = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MULT_CALC = 3'd1,
    DIV_CALC  = 3'd2,
    RESULT    = 3'd3,
    DIVZERO   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;      // Booth accumulator / division remainder
  logic [WIDTH-1:0] q_q, q_d;          // multiplier / dividend shifting into quotient
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   m_q, m_d;          // sign-extended multiplicand / zero-extended divisor
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             fast_zero_mult, fast_zero_div;

  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_mag     = b[WIDTH-1] ? -b : b;
  assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign div_trial = div_shift - m_q;

`ifdef MULTDIV_FAST_ZERO_EN
  assign fast_zero_mult = (a == '0) || (b == '0);
  assign fast_zero_div  = (a == '0);
`else
  assign fast_zero_mult = 1'b0;
  assign fast_zero_div  = 1'b0;
`endif

  always_comb begin
    booth_sum = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b10:   booth_sum = acc_q - m_q;
      2'b01:   booth_sum = acc_q + m_q;
      default: booth_sum = acc_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && op == OP_MULT) begin
          acc_d    = '0;
          q_d      = fast_zero_mult ? '0 : b;
          qm1_d    = 1'b0;
          m_d      = {a[WIDTH-1], a};
          cnt_d    = CNT_INIT;
          is_div_d = 1'b0;
          state_d  = fast_zero_mult ? RESULT : MULT_CALC;
        end else if (start && op == OP_DIV) begin
          if (b == '0) begin
            // done/div0 are registered, so they are visible during the DIVZERO cycle
            done_d  = 1'b1;
            div0_d  = 1'b1;
            state_d = DIVZERO;
          end else begin
            acc_d     = '0;
            q_d       = a_mag;
            m_d       = {1'b0, b_mag};
            cnt_d     = CNT_INIT;
            is_div_d  = 1'b1;
            neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_d = a[WIDTH-1];
            state_d   = fast_zero_div ? RESULT : DIV_CALC;
          end
        end
      end

      MULT_CALC: begin
        acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = RESULT;
      end

      DIV_CALC: begin
        // A negative trial difference means the divisor did not fit: keep the shifted remainder
        acc_d = div_trial[WIDTH] ? div_shift : div_trial;
        q_d   = {q_q[WIDTH-2:0], ~div_trial[WIDTH]};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = RESULT;
      end

      RESULT: begin
        if (is_div_q) begin
          lo_d = neg_quo_q ? -q_q : q_q;
          hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end else begin
          lo_d = q_q;
          hi_d = acc_q[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      DIVZERO: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == MULT_CALC) || (state_q == DIV_CALC) || (state_q == RESULT);
  assign done        = done_q;
  assign div0        = div0_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random commands against a 64-bit arithmetic model.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div0;
  logic [W-1:0] hi, lo;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div0        (div0),
    .hi          (hi),
    .lo          (lo),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: plain 64-bit signed arithmetic; SV / and % truncate toward zero
  // and give the remainder the dividend's sign, matching the HI/LO rules.
  task automatic model(input logic [1:0] op_v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [2*W-1:0] res, output logic exp_div0, output int lat);
    longint sa, sb, prod, qt, rm;
    sa       = longint'($signed(av));
    sb       = longint'($signed(bv));
    exp_div0 = 1'b0;
    lat      = 33;
    if (op_v == OP_MULT) begin
      prod = sa * sb;
      res  = prod;
`ifdef MULTDIV_FAST_ZERO_EN
      if (av == 0 || bv == 0) lat = 1;
`endif
    end else if (bv == 0) begin
      res      = {m_hi, m_lo};
      exp_div0 = 1'b1;
      lat      = 0;
    end else begin
      qt  = sa / sb;
      rm  = sa % sb;
      res = {rm[W-1:0], qt[W-1:0]};
`ifdef MULTDIV_FAST_ZERO_EN
      if (av == 0) lat = 1;
`endif
    end
    {m_hi, m_lo} = res;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // driver: issue one command, scramble inputs after E0, optionally re-pulse start while busy
  task automatic run_op(input logic [1:0] op_v, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int pulse_at);
    logic [2*W-1:0] res, got;
    logic           exp_div0;
    int             lat, edges;
    model(op_v, av, bv, res, exp_div0, lat);
    exp_q.push_back(res);
    @(negedge clock);
    start = 1'b1; op = op_v; a = av; b = bv;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom;
    edges = 0;
    check("busy_after_e0", busy, !exp_div0);
    while (done !== 1'b1 && edges < 60) begin
      if (edges == pulse_at) begin
        start = 1'b1; op = OP_MULT; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      edges++;
      check("busy_done_excl", busy & done, 0);
    end
    start = 1'b0;
    check($sformatf("done_seen_state%0d", dbg_state), done, 1);
    check("latency", edges, lat);
    got = exp_q.pop_front();
    check("hi", hi, got[2*W-1:W]);
    check("lo", lo, got[W-1:0]);
    check("div0", div0, exp_div0);
    check("busy_at_done", busy, 0);
    @(negedge clock);
    check("done_one_cycle", done, 0);
    check("div0_one_cycle", div0, 0);
  endtask

  initial begin
    logic seen_done;
    logic [1:0] rop;
    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div0", div0, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clock);
    reset = 1'b1;

    // op 00 / 11 are no-ops
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      start = 1'b1; op = (i == 0) ? 2'b00 : 2'b11; a = $urandom; b = $urandom;
      @(negedge clock);
      start = 1'b0;
      check("noop_busy", busy, 0);
      check("noop_done", done, 0);
    end

    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, -1);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, -1);
    run_op(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, -1);
    run_op(OP_DIV, 32'd100, 32'd0, -1);
    run_op(OP_MULT, 32'd0, 32'd5, -1);
    run_op(OP_DIV, 32'd0, 32'd9, -1);
    run_op(OP_DIV, 32'd12345, 32'hFFFF_FFF0, -1);
    run_op(OP_MULT, 32'h0001_2345, 32'hFFFF_8001, 4);

    // reset during a MULT: abort, clear HI/LO, no done
    @(negedge clock);
    start = 1'b1; op = OP_MULT; a = 32'h0BAD_CAFE; b = 32'h0000_1234;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      seen_done |= done;
    end
    check("abort_no_done", seen_done, 0);
    run_op(OP_MULT, 32'hFFFE_1DC0, 32'd789, -1);

    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
      run_op(rop, rand_operand(), rand_operand(),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide responder driven by the control unit's mult_div command.
- Takes operands from the A/B registers and runs radix-2 Booth multiplication or restoring division over 32 iterations.
- Writes the results into internal HI/LO registers and returns a done/div0 handshake to the control FSM.
- Feeds the mfhi/mflo datapath path and the div-by-zero exception path.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- start  in  1  command strobe; sampled only in IDLE.
- op  in  2  2'b01 = MULT, 2'b10 = DIV; 2'b00 and 2'b11 are no-op.
- a  in  WIDTH  multiplicand / dividend (rs).
- b  in  WIDTH  multiplier / divisor (rt).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO are valid when it is high.
- div0  out  1  one-cycle pulse on DIV with b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state = IDLE; busy = 0, done = 0, div0 = 0, hi = 0, lo = 0; all internal registers cleared.
- Reset while busy: operation aborted with no done; hi/lo return to 0.
- FSM states: IDLE, MULT_CALC, DIV_CALC, RESULT, DIVZERO.
- IDLE:
  - On edge E0 with start=1 and op=01: latch a/b, load the Booth accumulator, counter = WIDTH, go to MULT_CALC, busy = 1.
  - On E0 with op=10 and b!=0: latch |a|, |b| and both sign bits, counter = WIDTH, go to DIV_CALC, busy = 1.
  - On E0 with op=10 and b==0: go to DIVZERO with busy = 0.
  - start with op 00/11: ignored, stay in IDLE.
- MULT_CALC:
  - Each edge performs one Booth step using {Q0, Q-1}: 10 subtracts, 01 adds, then arithmetic right shift of {acc, Q, Q-1}.
  - The accumulator is WIDTH+1 bits so INT_MIN operands are exact.
  - Counter decrements; when it reaches 0, go to RESULT.
- DIV_CALC:
  - Each edge performs one restoring step on the magnitudes: shift the remainder left, trial-subtract the divisor, set the quotient bit, restore if the result is negative.
  - After WIDTH steps, go to RESULT.
- RESULT (one cycle):
  - MULT: {hi, lo} = exact signed 2*WIDTH product.
  - DIV: lo = quotient, negated when the signs of a and b differ; hi = remainder, carrying the sign of a.
  - done = 1 for one cycle, busy = 0, next state IDLE.
- DIVZERO (one cycle):
  - div0 = 1 and done = 1 for one cycle; hi/lo unchanged; next state IDLE.
- Latency:
  - MULT/DIV: start sampled at E0; 32 calc edges E1–E32; hi/lo updated and done high after E33.
  - DIVZERO: div0/done high in the cycle after E0.
- Rules:
  - start during busy is ignored and cannot corrupt latched operands.
  - a/b may change after E0 without effect.
  - hi/lo hold their values until the next RESULT or reset.
  - INT_MIN / -1: lo = 0x80000000, hi = 0, no div0.
  - done and busy are never both 1.

Optional Feature:
- Macro: MULTDIV_FAST_ZERO_EN.
- Defined:
  - MULT with a==0 or b==0 skips MULT_CALC and goes straight to RESULT, giving hi = lo = 0 with done after E1.
  - DIV with a==0 and b!=0 does the same, giving hi = lo = 0 with done after E1.
- Undefined: zero operands take the full 33-edge path; results are identical.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> done after E33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high E0–E33.
- MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. MULT a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
- DIV a=100, b=0 after a prior MULT leaves hi=H0/lo=L0 -> div0=1 and done=1 for exactly one cycle after E0; busy never 1; hi=H0, lo=L0.
- MULT started, reset driven low at E10 -> hi=lo=0, busy=0 immediately, no done pulse; a new MULT after release completes normally. start pulses at E5 with new operands during busy -> result is for the original operands.
- With MULTDIV_FAST_ZERO_EN: MULT a=0, b=5 -> done after E1, hi=lo=0. Without the macro: done after E33, same values.
